// File: rtl/ts_os_receiver_if.sv
// Decoded-symbol stream of one lane as it arrives from the 8b/10b decoder.
// The decoder side uses the master modport and the TS/OS receiver uses the slave modport.
interface ts_os_receiver_if;
  logic       rx_valid_i;
  logic [7:0] rx_data_i;
  logic       rx_datak_i;

  modport master (output rx_valid_i, output rx_data_i, output rx_datak_i);
  modport slave  (input  rx_valid_i, input  rx_data_i, input  rx_datak_i);
endinterface

// File: rtl/ts_os_receiver.sv
// TS1/TS2 ordered-set receiver: parses one lane, reports fields and consecutive-match count.
// Optional macro TS_INVERSION_DETECT_EN accepts polarity-inverted IDs and flags rx_inverted_o.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_HUNT    | waiting for COM; non-COM symbols are ignored silently
// ST_COLLECT | gathering symbols 1..15 of a set, idx = next symbol index
module ts_os_receiver #(
  parameter int CNT_W        = 4,
  parameter int MATCH_TARGET = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  ts_os_receiver_if.slave  rx,
  input  logic             ts_cnt_clr_i,
  output logic             ts_valid_o,
  output logic             ts_type_o,
  output logic [7:0]       ts_link_o,
  output logic             ts_link_pad_o,
  output logic [7:0]       ts_lane_o,
  output logic             ts_lane_pad_o,
  output logic [7:0]       ts_nfts_o,
  output logic [7:0]       ts_rate_o,
  output logic [7:0]       ts_ctrl_o,
  output logic [CNT_W-1:0] ts_consec_cnt_o,
  output logic             ts_target_met_o,
  output logic             ts_err_o,
  output logic             rx_inverted_o
);

  localparam logic [7:0] SYM_COM = 8'hBC;
  localparam logic [7:0] SYM_PAD = 8'hF7;
  localparam logic [7:0] ID_TS1  = 8'h4A;
  localparam logic [7:0] ID_TS2  = 8'h45;
`ifdef TS_INVERSION_DETECT_EN
  localparam logic [7:0] ID_TS1_INV = 8'hB5;
  localparam logic [7:0] ID_TS2_INV = 8'hBA;
`endif
  localparam logic [CNT_W:0] TARGET = (CNT_W+1)'(MATCH_TARGET);

  typedef enum logic {ST_HUNT, ST_COLLECT} state_t;

  state_t     state;
  logic [3:0] idx;
  logic [7:0] set_id;
  logic       set_type;
  logic [7:0] link_s, lane_s, nfts_s, rate_s, ctrl_s;
  logic       link_pad_s, lane_pad_s;

  logic       ref_valid, ref_type, ref_link_pad, ref_lane_pad;
  logic [7:0] ref_link, ref_lane, ref_rate, ref_ctrl;

  logic is_com, id_ok, id_ts2, sym_ok, complete, match;
`ifdef TS_INVERSION_DETECT_EN
  logic id_inv, set_inv;
`endif

  always_comb begin
    is_com = rx.rx_datak_i && (rx.rx_data_i == SYM_COM);
    id_ok  = 1'b0;
    id_ts2 = 1'b0;
`ifdef TS_INVERSION_DETECT_EN
    id_inv = 1'b0;
`endif
    if (!rx.rx_datak_i) begin
      case (rx.rx_data_i)
        ID_TS1:     id_ok = 1'b1;
        ID_TS2:     begin id_ok = 1'b1; id_ts2 = 1'b1; end
`ifdef TS_INVERSION_DETECT_EN
        ID_TS1_INV: begin id_ok = 1'b1; id_inv = 1'b1; end
        ID_TS2_INV: begin id_ok = 1'b1; id_ts2 = 1'b1; id_inv = 1'b1; end
`endif
        default:    id_ok = 1'b0;
      endcase
    end

    case (idx)
      4'd1, 4'd2:       sym_ok = !rx.rx_datak_i || (rx.rx_data_i == SYM_PAD);
      4'd3, 4'd4, 4'd5: sym_ok = !rx.rx_datak_i;
      4'd6:             sym_ok = id_ok;
      default:          sym_ok = !rx.rx_datak_i && (rx.rx_data_i == set_id);
    endcase

    complete = (state == ST_COLLECT) && rx.rx_valid_i && !is_com && sym_ok && (idx == 4'd15);

    // N_FTS is deliberately left out of the identity check.
    match = ref_valid && (ref_type == set_type) &&
            (ref_link == link_s) && (ref_link_pad == link_pad_s) &&
            (ref_lane == lane_s) && (ref_lane_pad == lane_pad_s) &&
            (ref_rate == rate_s) && (ref_ctrl == ctrl_s);
  end

  assign ts_target_met_o = ({1'b0, ts_consec_cnt_o} >= TARGET);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= ST_HUNT;
      idx             <= 4'd0;
      set_id          <= 8'h00;
      set_type        <= 1'b0;
      link_s          <= 8'h00;
      lane_s          <= 8'h00;
      nfts_s          <= 8'h00;
      rate_s          <= 8'h00;
      ctrl_s          <= 8'h00;
      link_pad_s      <= 1'b0;
      lane_pad_s      <= 1'b0;
      ref_valid       <= 1'b0;
      ref_type        <= 1'b0;
      ref_link        <= 8'h00;
      ref_link_pad    <= 1'b0;
      ref_lane        <= 8'h00;
      ref_lane_pad    <= 1'b0;
      ref_rate        <= 8'h00;
      ref_ctrl        <= 8'h00;
      ts_valid_o      <= 1'b0;
      ts_type_o       <= 1'b0;
      ts_link_o       <= 8'h00;
      ts_link_pad_o   <= 1'b0;
      ts_lane_o       <= 8'h00;
      ts_lane_pad_o   <= 1'b0;
      ts_nfts_o       <= 8'h00;
      ts_rate_o       <= 8'h00;
      ts_ctrl_o       <= 8'h00;
      ts_consec_cnt_o <= '0;
      ts_err_o        <= 1'b0;
`ifdef TS_INVERSION_DETECT_EN
      set_inv         <= 1'b0;
      rx_inverted_o   <= 1'b0;
`endif
    end else begin
      ts_valid_o <= 1'b0;
      ts_err_o   <= 1'b0;

      if (rx.rx_valid_i) begin
        case (state)
          ST_HUNT: begin
            if (is_com) begin
              state <= ST_COLLECT;
              idx   <= 4'd1;
            end
          end
          ST_COLLECT: begin
            if (is_com) begin
              // resync onto the new COM rather than hunting for the next one
              ts_err_o <= 1'b1;
              idx      <= 4'd1;
            end else if (!sym_ok) begin
              ts_err_o <= 1'b1;
              state    <= ST_HUNT;
              idx      <= 4'd0;
            end else begin
              case (idx)
                4'd1: begin link_s <= rx.rx_data_i; link_pad_s <= rx.rx_datak_i; end
                4'd2: begin lane_s <= rx.rx_data_i; lane_pad_s <= rx.rx_datak_i; end
                4'd3: nfts_s <= rx.rx_data_i;
                4'd4: rate_s <= rx.rx_data_i;
                4'd5: ctrl_s <= rx.rx_data_i;
                4'd6: begin
                  set_id   <= rx.rx_data_i;
                  set_type <= id_ts2;
`ifdef TS_INVERSION_DETECT_EN
                  set_inv  <= id_inv;
`endif
                end
                default: ;
              endcase
              if (idx == 4'd15) begin
                state         <= ST_HUNT;
                idx           <= 4'd0;
                ts_valid_o    <= 1'b1;
                ts_type_o     <= set_type;
                ts_link_o     <= link_s;
                ts_link_pad_o <= link_pad_s;
                ts_lane_o     <= lane_s;
                ts_lane_pad_o <= lane_pad_s;
                ts_nfts_o     <= nfts_s;
                ts_rate_o     <= rate_s;
                ts_ctrl_o     <= ctrl_s;
              end else begin
                idx <= idx + 4'd1;
              end
            end
          end
          default: state <= ST_HUNT;
        endcase
      end

      // a clear coinciding with a completion still adopts the new set as reference
      if (complete) begin
        ref_valid    <= 1'b1;
        ref_type     <= set_type;
        ref_link     <= link_s;
        ref_link_pad <= link_pad_s;
        ref_lane     <= lane_s;
        ref_lane_pad <= lane_pad_s;
        ref_rate     <= rate_s;
        ref_ctrl     <= ctrl_s;
        if (ts_cnt_clr_i || !match)
          ts_consec_cnt_o <= CNT_W'(1);
        else if (!(&ts_consec_cnt_o))
          ts_consec_cnt_o <= ts_consec_cnt_o + CNT_W'(1);
`ifdef TS_INVERSION_DETECT_EN
        if (set_inv)
          rx_inverted_o <= 1'b1;
`endif
      end else if (ts_cnt_clr_i) begin
        ref_valid       <= 1'b0;
        ts_consec_cnt_o <= '0;
      end
    end
  end

`ifndef TS_INVERSION_DETECT_EN
  assign rx_inverted_o = 1'b0;
`endif

endmodule

// File: tb/tb_ts_os_receiver.sv
// Directed bench for ts_os_receiver: table of whole TS sets plus hand-written corner sequences.
module tb_ts_os_receiver;
  localparam int CNT_W = 4;
  localparam int MT    = 8;

  logic clk_i = 1'b0;
  logic rst_i;
  logic ts_cnt_clr_i;
  logic ts_valid_o, ts_type_o, ts_link_pad_o, ts_lane_pad_o, ts_target_met_o, ts_err_o, rx_inverted_o;
  logic [7:0] ts_link_o, ts_lane_o, ts_nfts_o, ts_rate_o, ts_ctrl_o;
  logic [CNT_W-1:0] ts_consec_cnt_o;

  always #5 clk_i = ~clk_i;

  ts_os_receiver_if rx_if ();

  ts_os_receiver #(.CNT_W(CNT_W), .MATCH_TARGET(MT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx(rx_if.slave), .ts_cnt_clr_i(ts_cnt_clr_i),
    .ts_valid_o(ts_valid_o), .ts_type_o(ts_type_o), .ts_link_o(ts_link_o),
    .ts_link_pad_o(ts_link_pad_o), .ts_lane_o(ts_lane_o), .ts_lane_pad_o(ts_lane_pad_o),
    .ts_nfts_o(ts_nfts_o), .ts_rate_o(ts_rate_o), .ts_ctrl_o(ts_ctrl_o),
    .ts_consec_cnt_o(ts_consec_cnt_o), .ts_target_met_o(ts_target_met_o),
    .ts_err_o(ts_err_o), .rx_inverted_o(rx_inverted_o)
  );

  typedef struct {
    logic       ts2;
    logic [7:0] link;  logic link_pad;
    logic [7:0] lane;  logic lane_pad;
    logic [7:0] nfts;  logic [7:0] rate; logic [7:0] ctrl;
    logic [7:0] id;
    int         bad_idx; logic [7:0] bad_data; logic bad_k;
    logic       exp_valid; logic exp_err;
    int         exp_cnt;   logic exp_met;
  } vec_t;

  typedef logic [8:0] sym_arr_t [16];

  int n_tests = 0;
  int n_fail  = 0;
  int acc_v, acc_e;
  logic last_v;
  vec_t tbl [20];
  vec_t vb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ts2, input logic [7:0] link, input logic lp,
                              input logic [7:0] lane, input logic np, input logic [7:0] nfts,
                              input int cnt);
    vec_t v;
    v.ts2 = ts2; v.link = link; v.link_pad = lp; v.lane = lane; v.lane_pad = np;
    v.nfts = nfts; v.rate = 8'h02; v.ctrl = 8'h00;
    v.id = ts2 ? 8'h45 : 8'h4A;
    v.bad_idx = -1; v.bad_data = 8'h00; v.bad_k = 1'b0;
    v.exp_valid = 1'b1; v.exp_err = 1'b0;
    v.exp_cnt = cnt; v.exp_met = (cnt >= MT);
    return v;
  endfunction

  function automatic sym_arr_t build(input vec_t v);
    sym_arr_t s;
    s[0] = {1'b1, 8'hBC};
    s[1] = {v.link_pad, v.link};
    s[2] = {v.lane_pad, v.lane};
    s[3] = {1'b0, v.nfts};
    s[4] = {1'b0, v.rate};
    s[5] = {1'b0, v.ctrl};
    for (int i = 6; i < 16; i++) s[i] = {1'b0, v.id};
    if (v.bad_idx >= 0) s[v.bad_idx] = {v.bad_k, v.bad_data};
    return s;
  endfunction

  task automatic send_sym(input logic [8:0] sym, input bit clr);
    rx_if.rx_valid_i = 1'b1;
    rx_if.rx_datak_i = sym[8];
    rx_if.rx_data_i  = sym[7:0];
    ts_cnt_clr_i     = clr;
    @(posedge clk_i); #1;
    rx_if.rx_valid_i = 1'b0;
    ts_cnt_clr_i     = 1'b0;
    acc_v += int'(ts_valid_o);
    acc_e += int'(ts_err_o);
    last_v = ts_valid_o;
  endtask

  task automatic idle_cycle();
    @(posedge clk_i); #1;
    acc_v += int'(ts_valid_o);
    acc_e += int'(ts_err_o);
  endtask

  task automatic send_set(input vec_t v, input bit gaps, input bit clr_last);
    sym_arr_t s;
    s = build(v);
    for (int i = 0; i < 16; i++) begin
      send_sym(s[i], clr_last && (i == 15));
      if (gaps && i < 15) idle_cycle();
    end
  endtask

  task automatic chk_set(input string nm, input int ev, input int ee, input int ecnt);
    chk({nm, " valid_cnt"}, acc_v, ev);
    chk({nm, " err_cnt"}, acc_e, ee);
    chk({nm, " valid_last"}, {31'd0, last_v}, (ev > 0) ? 1 : 0);
    chk({nm, " consec"}, {28'd0, ts_consec_cnt_o}, ecnt);
    chk({nm, " met"}, {31'd0, ts_target_met_o}, (ecnt >= MT) ? 1 : 0);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " valid"}, {31'd0, ts_valid_o}, 0);
    chk({nm, " err"}, {31'd0, ts_err_o}, 0);
    chk({nm, " consec"}, {28'd0, ts_consec_cnt_o}, 0);
    chk({nm, " met"}, {31'd0, ts_target_met_o}, 0);
    chk({nm, " fields"}, {ts_type_o, ts_link_pad_o, ts_lane_pad_o, ts_link_o, ts_lane_o}, 0);
    chk({nm, " fields2"}, {8'd0, ts_nfts_o, ts_rate_o, ts_ctrl_o}, 0);
    chk({nm, " inverted"}, {31'd0, rx_inverted_o}, 0);
  endtask

  initial begin
    rst_i = 1'b1; ts_cnt_clr_i = 1'b0;
    rx_if.rx_valid_i = 1'b0; rx_if.rx_data_i = 8'h00; rx_if.rx_datak_i = 1'b0;
    acc_v = 0; acc_e = 0; last_v = 1'b0;

    for (int i = 0; i < 8; i++) tbl[i] = mk(1'b0, 8'hF7, 1'b1, 8'hF7, 1'b1, 8'h10, i + 1);
    tbl[8]  = mk(1'b0, 8'hF7, 1'b1, 8'hF7, 1'b1, 8'h20, 9);
    tbl[9]  = mk(1'b1, 8'hF7, 1'b1, 8'hF7, 1'b1, 8'h10, 1);
    tbl[10] = mk(1'b0, 8'h05, 1'b0, 8'h03, 1'b0, 8'h18, 1);
    tbl[11] = mk(1'b0, 8'h05, 1'b0, 8'h03, 1'b0, 8'h18, 2);
    tbl[12] = mk(1'b0, 8'h05, 1'b0, 8'h03, 1'b0, 8'h18, 3);
    tbl[13] = mk(1'b1, 8'h05, 1'b0, 8'h03, 1'b0, 8'h18, 1);
    tbl[14] = mk(1'b1, 8'h05, 1'b0, 8'h03, 1'b0, 8'h18, 2);
    tbl[15] = mk(1'b1, 8'h05, 1'b0, 8'h03, 1'b0, 8'h18, 2);
    tbl[15].bad_idx = 9; tbl[15].bad_data = 8'h4B; tbl[15].exp_valid = 0; tbl[15].exp_err = 1;
    tbl[16] = mk(1'b1, 8'h05, 1'b0, 8'h03, 1'b0, 8'h18, 3);
    tbl[17] = mk(1'b1, 8'h05, 1'b0, 8'h03, 1'b0, 8'h18, 3);
    tbl[17].bad_idx = 3; tbl[17].bad_data = 8'h3C; tbl[17].bad_k = 1; tbl[17].exp_valid = 0; tbl[17].exp_err = 1;
    tbl[18] = mk(1'b1, 8'h05, 1'b0, 8'h03, 1'b0, 8'h18, 3);
    tbl[18].bad_idx = 1; tbl[18].bad_data = 8'h7C; tbl[18].bad_k = 1; tbl[18].exp_valid = 0; tbl[18].exp_err = 1;
`ifdef TS_INVERSION_DETECT_EN
    tbl[19] = mk(1'b0, 8'h05, 1'b0, 8'h03, 1'b0, 8'h18, 1);
    tbl[19].id = 8'hB5;
`else
    tbl[19] = mk(1'b0, 8'h05, 1'b0, 8'h03, 1'b0, 8'h18, 3);
    tbl[19].id = 8'hB5; tbl[19].exp_valid = 0; tbl[19].exp_err = 1;
`endif

    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk_reset("reset");

    for (int i = 0; i < 20; i++) begin
      acc_v = 0; acc_e = 0; last_v = 1'b0;
      send_set(tbl[i], 1'b0, 1'b0);
      chk_set($sformatf("r%0d", i), tbl[i].exp_valid ? 1 : 0, tbl[i].exp_err ? 1 : 0, tbl[i].exp_cnt);
      if (tbl[i].exp_valid) begin
        chk($sformatf("r%0d type", i), {31'd0, ts_type_o}, {31'd0, tbl[i].ts2});
        chk($sformatf("r%0d link", i), {23'd0, ts_link_pad_o, ts_link_o}, {23'd0, tbl[i].link_pad, tbl[i].link});
        chk($sformatf("r%0d lane", i), {23'd0, ts_lane_pad_o, ts_lane_o}, {23'd0, tbl[i].lane_pad, tbl[i].lane});
        chk($sformatf("r%0d nfts_rate_ctrl", i), {8'd0, ts_nfts_o, ts_rate_o, ts_ctrl_o},
            {8'd0, tbl[i].nfts, tbl[i].rate, tbl[i].ctrl});
      end
    end
`ifdef TS_INVERSION_DETECT_EN
    chk("inverted after r19", {31'd0, rx_inverted_o}, 1);
`else
    chk("inverted tied low", {31'd0, rx_inverted_o}, 0);
`endif

    // COM at index 10 of a partial set, then a full set
    vb = mk(1'b0, 8'h07, 1'b0, 8'h01, 1'b0, 8'h18, 1);
    begin
      sym_arr_t s;
      s = build(vb);
      acc_v = 0; acc_e = 0; last_v = 1'b0;
      for (int i = 0; i < 10; i++) send_sym(s[i], 1'b0);
      send_set(vb, 1'b0, 1'b0);
      chk_set("com_resync", 1, 1, 1);
    end

    // rx_valid toggling through two sets
    for (int j = 0; j < 2; j++) begin
      acc_v = 0; acc_e = 0; last_v = 1'b0;
      send_set(vb, 1'b1, 1'b0);
      chk_set($sformatf("gap%0d", j), 1, 0, 2 + j);
    end

    ts_cnt_clr_i = 1'b1;
    @(posedge clk_i); #1 ts_cnt_clr_i = 1'b0;
    chk("clr consec", {28'd0, ts_consec_cnt_o}, 0);
    chk("clr met", {31'd0, ts_target_met_o}, 0);
    acc_v = 0; acc_e = 0; last_v = 1'b0;
    send_set(vb, 1'b0, 1'b0);
    chk_set("after_clr", 1, 0, 1);

    // clear on the completing cycle: count 1, set becomes the reference
    acc_v = 0; acc_e = 0; last_v = 1'b0;
    send_set(vb, 1'b0, 1'b1);
    chk_set("clr_on_done", 1, 0, 1);
    acc_v = 0; acc_e = 0; last_v = 1'b0;
    send_set(vb, 1'b0, 1'b0);
    chk_set("after_clr_on_done", 1, 0, 2);

    acc_v = 0; acc_e = 0; last_v = 1'b0;
    send_sym({1'b0, 8'h4A}, 1'b0);
    send_sym({1'b1, 8'h7C}, 1'b0);
    send_sym({1'b1, 8'hF7}, 1'b0);
    send_sym({1'b0, 8'h00}, 1'b0);
    chk("hunt garbage err", acc_e, 0);
    chk("hunt garbage valid", acc_v, 0);

    ts_cnt_clr_i = 1'b1;
    @(posedge clk_i); #1 ts_cnt_clr_i = 1'b0;
    for (int j = 0; j < 16; j++) begin
      acc_v = 0; acc_e = 0; last_v = 1'b0;
      send_set(vb, 1'b0, 1'b0);
      chk_set($sformatf("sat%0d", j), 1, 0, (j + 1 > 15) ? 15 : j + 1);
    end

`ifdef TS_INVERSION_DETECT_EN
    chk("inverted sticky", {31'd0, rx_inverted_o}, 1);
`endif
    rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    chk_reset("final_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
